u_dmem: RTL and testbench
=========================

Name: u_dmem

Overview:
- Data-memory responder on the CPU's data port: consumes data address, write data, word/byte select and write strobe from u_cpu; returns load data on the CPU's data input.
- Big-endian byte lanes, MIPS convention.
- A one-entry store buffer registers each store, commits it to the array one cycle later, and forwards pending bytes to loads.
- Flags misaligned and out-of-range accesses.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array (power of two).
- AW, $clog2(DEPTH), word-index width.

Ports:
- i_sys_clock  in  1  system clock, rising edge.
- i_sys_reset  in  1  asynchronous, active-low reset.
- i_u_dmem_addr  in  32  byte address from o_u_cpu_data_addr.
- i_u_dmem_write_data  in  32  store data from o_u_cpu_write_data.
- i_u_dmem_word  in  1  1 = word access, 0 = byte access (from o_u_cpu_word).
- i_u_dmem_mem_wr  in  1  store strobe (from o_u_cpu_mem_wr).
- o_u_dmem_data  out  32  load data to i_u_cpu_data, combinational.
- o_u_dmem_err  out  1  sticky access-error flag.
- o_u_dmem_store_count  out  16  committed-store count (only with U_DMEM_STATS_EN).

Behaviour:
- Address decode:
  - index = addr[AW+1:2]; lane = addr[1:0].
  - in_range = (addr[31:AW+2] == 0).
  - Lane 0 = bits[31:24], lane 3 = bits[7:0].
- Error conditions: word access with lane != 0 is misaligned; any access with in_range = 0 is out of range.
- Store capture (posedge, mem_wr = 1, no error):
  - pend_valid <= 1, pend_idx <= index.
  - Word store: pend_be = 4'b1111, pend_data = write_data.
  - Byte store: pend_be = one-hot lane, write_data[7:0] replicated to all lanes.
- Erroneous store: not captured; o_u_dmem_err <= 1.
- Commit: whenever pend_valid = 1 at a posedge, the enabled bytes are written to array[pend_idx].
  - pend_valid clears unless a new store is captured on the same edge.
  - Back-to-back stores therefore sustain one store per cycle with no stall.
- Load path (combinational, every cycle):
  - word = array[index], with the pending bytes merged in when pend_valid and pend_idx == index.
  - Word access: o_u_dmem_data = word.
  - Byte access: {24'h0, selected lane} (zero-extended; the CPU sign-extends).
  - Error address: data = 0. A load error also sets err at the next posedge, but only when mem_wr = 0. The CPU has no read strobe, so err is meaningful only while a load or store is actually in MEM.
- Store and load to the same index in one cycle: the load sees the old value plus any older pending bytes. The new store becomes visible in the next cycle via forwarding.
- Reset:
  - o_u_dmem_err = 0, pend_valid = 0, store_count = 0.
  - A store pending at reset is discarded (never committed).
  - Array contents are not reset.
- After reset, o_u_dmem_data reflects array contents; simulation X is acceptable for unwritten words.

Optional Feature:
- Macro: U_DMEM_STATS_EN.
- Defined: o_u_dmem_store_count increments on every commit, saturating at 16'hFFFF, reset to 0.
- Undefined: the port and counter are absent; other behaviour is identical.

Decomposition:
- Package u_dmem_pkg holds:
  - typedef be_t (logic [3:0]);
  - LANE_* constants;
  - function lane_mask(lane) -> be_t;
  - function merge_bytes(word, data, be) -> 32-bit.
- Sub-module u_dmem_stbuf: pending-entry registers, commit enable and forward-merge output.
- The top holds the array, decode, error logic and load mux.

Test Plan:
- Reset low mid-store (sw 0x12341E61 to 0x3E8 captured, reset asserted before commit) -> after release, read 0x3E8 ≠ 0x12341E61 from the store; err = 0.
- sw 0x12341E61 to 0x3E8 -> same-cycle read gives old value; next cycle gives 0x12341E61 (forwarded); two cycles later gives 0x12341E61 (from array).
- Word 0x12341E61 at 0x3E8, then sb 0x3A at 0x3E9 -> word read 0x3E8 = 0x123A1E61; byte read 0x3E9 = 0x0000003A.
- Back-to-back sb 0xAA@0x10, 0xBB@0x11, 0xCC@0x12, 0xDD@0x13 -> word read 0x10 = 0xAABBCCDD; with U_DMEM_STATS_EN, count = 4.
- sw to 0x3EA (misaligned) -> array unchanged, err = 1 from the next cycle and stays 1.
- sw to 0x00001000 with DEPTH = 1024 (out of range) -> no write, err = 1, load data = 0.

Source files
------------

// File: rtl/u_dmem_pkg.sv
// Shared types and helpers for the u_dmem data memory.
// Byte lanes are big-endian: lane 0 is bits [31:24] and lane 3 is bits [7:0].
// Byte-enable bit b covers bits [8*b+7:8*b], so lane L maps to enable bit 3-L.
package u_dmem_pkg;

    typedef logic [3:0] be_t;

    localparam logic [1:0] LANE_0 = 2'd0;
    localparam logic [1:0] LANE_1 = 2'd1;
    localparam logic [1:0] LANE_2 = 2'd2;
    localparam logic [1:0] LANE_3 = 2'd3;

    // One-hot byte enable for a single big-endian lane.
    function automatic be_t lane_mask(input logic [1:0] lane);
        return be_t'(4'b1000 >> lane);
    endfunction

    // Replace the bytes of word selected by be with the matching bytes of data.
    function automatic logic [31:0] merge_bytes(input logic [31:0] word,
                                                input logic [31:0] data,
                                                input be_t         be);
        logic [31:0] res;
        res = word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/u_dmem_stbuf.sv
// One-entry store buffer for u_dmem.
// Holds the most recent store for one cycle, presents it to the array as a
// commit request, and merges its pending bytes into loads of the same word.
module u_dmem_stbuf
    import u_dmem_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cap_i,
    input  logic [AW-1:0] cap_idx_i,
    input  be_t           cap_be_i,
    input  logic [31:0]   cap_data_i,
    input  logic [AW-1:0] look_idx_i,
    input  logic [31:0]   arr_word_i,
    output logic          commit_o,
    output logic [AW-1:0] commit_idx_o,
    output be_t           commit_be_o,
    output logic [31:0]   commit_data_o,
    output logic [31:0]   fwd_word_o
);

    logic          valid_q, valid_d;
    logic [AW-1:0] idx_q, idx_d;
    be_t           be_q, be_d;
    logic [31:0]   data_q, data_d;

    // Next entry: a captured store replaces the entry, otherwise the entry drains.
    always_comb begin
        valid_d = cap_i;
        idx_d   = idx_q;
        be_d    = be_q;
        data_d  = data_q;
        if (cap_i) begin
            idx_d  = cap_idx_i;
            be_d   = cap_be_i;
            data_d = cap_data_i;
        end
    end

    // Entry registers; reset drops any pending store without committing it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            be_q    <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            data_q  <= data_d;
        end
    end

    assign commit_o      = valid_q;
    assign commit_idx_o  = idx_q;
    assign commit_be_o   = be_q;
    assign commit_data_o = data_q;

    // Forward pending bytes when the load targets the buffered word.
    always_comb begin
        fwd_word_o = arr_word_i;
        if (valid_q && (idx_q == look_idx_i)) begin
            fwd_word_o = merge_bytes(arr_word_i, data_q, be_q);
        end
    end

endmodule

// File: rtl/u_dmem.sv
// u_dmem: CPU data-port memory responder, big-endian byte lanes.
// Stores pass through a one-entry buffer and reach the array one cycle later;
// loads are combinational and see buffered bytes via forwarding.
// Misaligned word accesses and out-of-range addresses raise a sticky error.
// Optional macro U_DMEM_STATS_EN adds a saturating committed-store counter.
module u_dmem
    import u_dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        i_sys_clock,
    input  logic        i_sys_reset,
    input  logic [31:0] i_u_dmem_addr,
    input  logic [31:0] i_u_dmem_write_data,
    input  logic        i_u_dmem_word,
    input  logic        i_u_dmem_mem_wr,
    output logic [31:0] o_u_dmem_data,
    output logic        o_u_dmem_err
`ifdef U_DMEM_STATS_EN
    ,
    output logic [15:0] o_u_dmem_store_count
`endif
);

    logic [31:0]   mem_q [DEPTH];

    logic [AW-1:0] index;
    logic [1:0]    lane;
    logic          in_range;
    logic          acc_err;
    logic          store_cap;
    be_t           cap_be;
    logic [31:0]   cap_data;

    logic          commit;
    logic [AW-1:0] commit_idx;
    be_t           commit_be;
    logic [31:0]   commit_data;
    logic [31:0]   fwd_word;

    logic          err_q, err_d;

    assign index     = i_u_dmem_addr[AW+1:2];
    assign lane      = i_u_dmem_addr[1:0];
    assign in_range  = (i_u_dmem_addr[31:AW+2] == '0);
    assign acc_err   = !in_range || (i_u_dmem_word && (lane != LANE_0));
    assign store_cap = i_u_dmem_mem_wr && !acc_err;
    assign cap_be    = i_u_dmem_word ? 4'b1111 : lane_mask(lane);
    assign cap_data  = i_u_dmem_word ? i_u_dmem_write_data
                                     : {4{i_u_dmem_write_data[7:0]}};

    u_dmem_stbuf #(
        .AW (AW)
    ) u_stbuf (
        .clk_i         (i_sys_clock),
        .rst_ni        (i_sys_reset),
        .cap_i         (store_cap),
        .cap_idx_i     (index),
        .cap_be_i      (cap_be),
        .cap_data_i    (cap_data),
        .look_idx_i    (index),
        .arr_word_i    (mem_q[index]),
        .commit_o      (commit),
        .commit_idx_o  (commit_idx),
        .commit_be_o   (commit_be),
        .commit_data_o (commit_data),
        .fwd_word_o    (fwd_word)
    );

    // Array commit: write the enabled bytes of the buffered store; no reset.
    always_ff @(posedge i_sys_clock) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (commit_be[b]) mem_q[commit_idx][8*b +: 8] <= commit_data[8*b +: 8];
            end
        end
    end

    // Sticky error: any bad address seen at a clock edge, load or store.
    always_comb begin
        err_d = err_q || acc_err;
    end

    // Error flag register.
    always_ff @(posedge i_sys_clock or negedge i_sys_reset) begin
        if (!i_sys_reset) err_q <= 1'b0;
        else              err_q <= err_d;
    end

    assign o_u_dmem_err = err_q;

    // Load mux: whole word or one zero-extended lane; bad addresses read zero.
    always_comb begin
        o_u_dmem_data = '0;
        if (!acc_err) begin
            if (i_u_dmem_word) begin
                o_u_dmem_data = fwd_word;
            end else begin
                case (lane)
                    LANE_0: o_u_dmem_data = {24'h0, fwd_word[31:24]};
                    LANE_1: o_u_dmem_data = {24'h0, fwd_word[23:16]};
                    LANE_2: o_u_dmem_data = {24'h0, fwd_word[15:8]};
                    LANE_3: o_u_dmem_data = {24'h0, fwd_word[7:0]};
                endcase
            end
        end
    end

`ifdef U_DMEM_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    // Count commits, holding at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (commit && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    // Store counter register.
    always_ff @(posedge i_sys_clock or negedge i_sys_reset) begin
        if (!i_sys_reset) cnt_q <= '0;
        else              cnt_q <= cnt_d;
    end

    assign o_u_dmem_store_count = cnt_q;
`endif

endmodule

// File: tb/tb_u_dmem.sv
// Testbench for u_dmem (DEPTH = 1024, byte addresses 0..4095 in range).
module tb_u_dmem;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr  = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        word  = 1'b1;
    logic        wr    = 1'b0;
    logic [31:0] data;
    logic        err;
`ifdef U_DMEM_STATS_EN
    logic [15:0] cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    u_dmem dut (
        .i_sys_clock         (clk),
        .i_sys_reset         (rst_n),
        .i_u_dmem_addr       (addr),
        .i_u_dmem_write_data (wdata),
        .i_u_dmem_word       (word),
        .i_u_dmem_mem_wr     (wr),
        .o_u_dmem_data       (data),
        .o_u_dmem_err        (err)
`ifdef U_DMEM_STATS_EN
        ,
        .o_u_dmem_store_count (cnt)
`endif
    );

    // Clock and reset block.
    always #5 clk = ~clk;

    // Behavioural model: byte-addressed durable memory plus the last store,
    // which is visible from the cycle after it is presented and becomes
    // durable one edge later unless reset intervenes.
    logic [7:0]  dur_m   [4096];
    bit          known_m [4096];
    bit          rec_v = 1'b0;
    logic [31:0] rec_a = 32'h0;
    logic [31:0] rec_d = 32'h0;
    bit          rec_w = 1'b0;
    bit          err_m = 1'b0;
    int          cnt_m = 0;

    function automatic bit bad_access(input logic [31:0] a, input logic w);
        return (a >= 32'd4096) || (w && (a[1:0] != 2'd0));
    endfunction

    function automatic bit view_byte(input int b, output logic [7:0] v);
        bit hit;
        hit = rec_v && (rec_w ? ((b / 4) == int'(rec_a[11:2])) : (b == int'(rec_a[11:0])));
        if (hit) begin
            v = rec_w ? rec_d[8*(3 - (b % 4)) +: 8] : rec_d[7:0];
            return 1'b1;
        end
        v = dur_m[b];
        return known_m[b];
    endfunction

    // Returns 1 when every byte the load depends on is known.
    function automatic bit expect_load(input logic [31:0] a, input logic w,
                                       output logic [31:0] e);
        logic [7:0] v;
        bit ok;
        ok = 1'b1;
        e  = 32'h0;
        if (bad_access(a, w)) return 1'b1;
        if (w) begin
            for (int k = 0; k < 4; k++) begin
                ok = ok & view_byte(int'(a[11:0]) + k, v);
                e[8*(3 - k) +: 8] = v;
            end
        end else begin
            ok = view_byte(int'(a[11:0]), v);
            e  = {24'h0, v};
        end
        return ok;
    endfunction

    initial begin
        for (int i = 0; i < 4096; i++) known_m[i] = 1'b0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_v = 1'b0;
            err_m = 1'b0;
            cnt_m = 0;
        end else begin
            if (rec_v) begin
                if (rec_w) begin
                    for (int k = 0; k < 4; k++) begin
                        dur_m[int'(rec_a[11:2]) * 4 + k]   = rec_d[8*(3 - k) +: 8];
                        known_m[int'(rec_a[11:2]) * 4 + k] = 1'b1;
                    end
                end else begin
                    dur_m[int'(rec_a[11:0])]   = rec_d[7:0];
                    known_m[int'(rec_a[11:0])] = 1'b1;
                end
                if (cnt_m < 65535) cnt_m++;
            end
            if (bad_access(addr, word)) err_m = 1'b1;
            rec_v = wr && !bad_access(addr, word);
            rec_a = addr;
            rec_d = wdata;
            rec_w = word;
        end
    end

    // Scoreboard comparison.
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare process: every out-of-reset cycle, on the falling edge.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n) begin
            if (expect_load(addr, word, e)) chk("model_data", data, e);
            chk("model_err", {31'h0, err}, {31'h0, err_m});
`ifdef U_DMEM_STATS_EN
            chk("model_count", {16'h0, cnt}, 32'(cnt_m));
`endif
        end
    end

    // Driver tasks.
    task automatic cyc(input logic [31:0] a, input logic [31:0] d,
                       input logic w, input logic s);
        @(posedge clk);
        #1;
        addr  = a;
        wdata = d;
        word  = w;
        wr    = s;
    endtask

    task automatic lit(input string name, input logic [31:0] ed, input logic ee);
        @(negedge clk);
        chk({name, "_data"}, data, ed);
        chk({name, "_err"}, {31'h0, err}, {31'h0, ee});
    endtask

    task automatic rst_pulse();
        @(posedge clk);
        #1;
        addr  = 32'h0;
        wdata = 32'h0;
        word  = 1'b1;
        wr    = 1'b0;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

`ifdef U_DMEM_STATS_EN
    task automatic lit_cnt(input logic [15:0] e);
        @(negedge clk);
        chk("store_count", {16'h0, cnt}, {16'h0, e});
    endtask
`endif

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_err", {31'h0, err}, 32'h0);
`ifdef U_DMEM_STATS_EN
        chk("reset_count", {16'h0, cnt}, 32'h0);
`endif

        // Known background at 0x3E8, then a store killed by reset before commit.
        cyc(32'h3E8, 32'hDEADBEEF, 1'b1, 1'b1);
        cyc(32'h0, 32'h0, 1'b1, 1'b0);
        cyc(32'h0, 32'h0, 1'b1, 1'b0);
        cyc(32'h3E8, 32'h12341E61, 1'b1, 1'b1);
        rst_pulse();
        cyc(32'h3E8, 32'h0, 1'b1, 1'b0);
        lit("rst_drop", 32'hDEADBEEF, 1'b0);

        // Store: same cycle old, next cycle forwarded, then from array.
        cyc(32'h3E8, 32'h12341E61, 1'b1, 1'b1);
        lit("sw_same", 32'hDEADBEEF, 1'b0);
        cyc(32'h3E8, 32'h0, 1'b1, 1'b0);
        lit("sw_fwd", 32'h12341E61, 1'b0);
        cyc(32'h3E8, 32'h0, 1'b1, 1'b0);
        lit("sw_arr", 32'h12341E61, 1'b0);

        // Byte store into lane 1.
        cyc(32'h3E9, 32'h0000003A, 1'b0, 1'b1);
        lit("sb_same", 32'h00000034, 1'b0);
        cyc(32'h3E8, 32'h0, 1'b1, 1'b0);
        lit("sb_word", 32'h123A1E61, 1'b0);
        cyc(32'h3E9, 32'h0, 1'b0, 1'b0);
        lit("sb_byte", 32'h0000003A, 1'b0);
        cyc(32'h3EB, 32'h0, 1'b0, 1'b0);
        lit("sb_lane3", 32'h00000061, 1'b0);

        // Back-to-back byte stores.
        rst_pulse();
        cyc(32'h10, 32'h000000AA, 1'b0, 1'b1);
        cyc(32'h11, 32'h000000BB, 1'b0, 1'b1);
        cyc(32'h12, 32'h000000CC, 1'b0, 1'b1);
        cyc(32'h13, 32'h000000DD, 1'b0, 1'b1);
        cyc(32'h10, 32'h0, 1'b1, 1'b0);
        lit("b2b_word", 32'hAABBCCDD, 1'b0);
        cyc(32'h12, 32'h0, 1'b0, 1'b0);
        lit("b2b_byte2", 32'h000000CC, 1'b0);
        cyc(32'h13, 32'h0, 1'b0, 1'b0);
        lit("b2b_byte3", 32'h000000DD, 1'b0);
`ifdef U_DMEM_STATS_EN
        lit_cnt(16'd4);
`endif

        // Misaligned word store.
        cyc(32'h3EA, 32'h55555555, 1'b1, 1'b1);
        lit("mis_same", 32'h0, 1'b0);
        cyc(32'h3E8, 32'h0, 1'b1, 1'b0);
        lit("mis_next", 32'h123A1E61, 1'b1);
        cyc(32'h3E8, 32'h0, 1'b0, 1'b0);
        lit("mis_sticky", 32'h00000012, 1'b1);

        // Out-of-range store must not alias onto word 0.
        rst_pulse();
        cyc(32'h0, 32'h01020304, 1'b1, 1'b1);
        cyc(32'h1000, 32'h00000077, 1'b1, 1'b1);
        lit("oor_same", 32'h0, 1'b0);
        cyc(32'h1000, 32'h0, 1'b1, 1'b0);
        lit("oor_next", 32'h0, 1'b1);
        cyc(32'h0, 32'h0, 1'b1, 1'b0);
        lit("oor_alias", 32'h01020304, 1'b1);

        // Erroneous loads also raise the flag.
        rst_pulse();
        cyc(32'h3E9, 32'h0, 1'b1, 1'b0);
        lit("misld_same", 32'h0, 1'b0);
        cyc(32'h3E9, 32'h0, 1'b0, 1'b0);
        lit("misld_next", 32'h0000003A, 1'b1);
        cyc(32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
        lit("oor_byte", 32'h0, 1'b1);
        cyc(32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
